// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at the tail, completes entries
// out of order by index, and retires one completed head entry per cycle.
// Retiring a mispredicted or excepting entry raises a one-cycle flush
// that empties the whole buffer.
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int IDX_W     = $clog2(ROB_DEPTH),
  parameter int PREG_W    = 6,
  parameter int AREG_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [AREG_W-1:0] alloc_areg,
  input  logic [PREG_W-1:0] alloc_preg,
  input  logic [PREG_W-1:0] alloc_old_preg,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              ex_valid,
  input  logic [IDX_W-1:0]  ex_rob_entry_idx,
  input  logic [31:0]       ex_val,
  input  logic              ex_br_mispred,
  input  logic              ex_exception,
  output logic              commit_valid,
  output logic [AREG_W-1:0] commit_areg,
  output logic [PREG_W-1:0] commit_preg,
  output logic [PREG_W-1:0] commit_old_preg,
  output logic [31:0]       commit_val,
  output logic              flush,
  output logic              exception_out,
  output logic [IDX_W:0]    count
);

  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(ROB_DEPTH);
  localparam logic [IDX_W:0] PTR_ONE   = (IDX_W+1)'(1);

  // Pointers carry a wrap bit above the index bits
  logic [IDX_W:0] head_reg, tail_reg, count_reg;

  // Per-entry status bits, one bit per entry
  logic [ROB_DEPTH-1:0] valid_reg, done_reg, mispred_reg, exc_reg;
  logic [ROB_DEPTH-1:0] valid_next, done_next, mispred_next, exc_next;

  // Per-entry payload storage (no reset needed; guarded by valid)
  logic [AREG_W-1:0] areg_mem     [ROB_DEPTH];
  logic [PREG_W-1:0] preg_mem     [ROB_DEPTH];
  logic [PREG_W-1:0] old_preg_mem [ROB_DEPTH];
  logic [31:0]       val_mem      [ROB_DEPTH];

  // Registered commit-side outputs
  logic              commit_valid_reg;
  logic [AREG_W-1:0] commit_areg_reg;
  logic [PREG_W-1:0] commit_preg_reg;
  logic [PREG_W-1:0] commit_old_preg_reg;
  logic [31:0]       commit_val_reg;
  logic              flush_reg;
  logic              exception_out_reg;

  logic [IDX_W-1:0] head_idx, tail_idx;
  logic head_valid, head_done, head_mispred, head_exc;
  logic commit_cond, flush_cond, commit_fire, alloc_fire, ex_fire, ptr_full;

  assign head_idx     = head_reg[IDX_W-1:0];
  assign tail_idx     = tail_reg[IDX_W-1:0];
  assign head_valid   = valid_reg[head_idx];
  assign head_done    = done_reg[head_idx];
  assign head_mispred = mispred_reg[head_idx];
  assign head_exc     = exc_reg[head_idx];

  // Commit decision is made on registered done, so a completion is seen
  // by commit one cycle after it is written.
  assign commit_cond = head_valid && head_done;
  assign flush_cond  = commit_cond && (head_mispred || head_exc);
  assign commit_fire = commit_cond && !flush_cond;

  // The wrap-bit view of fullness always agrees with the counter; both are
  // kept so either can be trusted when debugging.
  assign ptr_full    = (head_reg[IDX_W] != tail_reg[IDX_W]) && (head_idx == tail_idx);
  assign alloc_ready = (count_reg != DEPTH_CNT) && !ptr_full && !flush_cond;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_idx   = tail_idx;

  // Stale completions (entry not valid) and completions during a flush drop
  assign ex_fire = ex_valid && valid_reg[ex_rob_entry_idx] && !flush_cond;

  generate
    for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
      logic alloc_hit, ex_hit, commit_hit;
      assign alloc_hit  = alloc_fire && (tail_idx == IDX_W'(gi));
      assign ex_hit     = ex_fire && (ex_rob_entry_idx == IDX_W'(gi));
      assign commit_hit = commit_fire && (head_idx == IDX_W'(gi));

      assign valid_next[gi]   = flush_cond ? 1'b0 :
                                alloc_hit  ? 1'b1 :
                                commit_hit ? 1'b0 : valid_reg[gi];
      assign done_next[gi]    = alloc_hit ? 1'b0 : ex_hit ? 1'b1 : done_reg[gi];
      assign mispred_next[gi] = alloc_hit ? 1'b0 : ex_hit ? ex_br_mispred : mispred_reg[gi];
      assign exc_next[gi]     = alloc_hit ? 1'b0 : ex_hit ? ex_exception : exc_reg[gi];
    end
  endgenerate

  // Entry status bits
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg   <= '0;
      done_reg    <= '0;
      mispred_reg <= '0;
      exc_reg     <= '0;
    end else begin
      valid_reg   <= valid_next;
      done_reg    <= done_next;
      mispred_reg <= mispred_next;
      exc_reg     <= exc_next;
    end
  end

  // Payload writes: dispatch fields at the tail, result value on completion
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      areg_mem[tail_idx]     <= alloc_areg;
      preg_mem[tail_idx]     <= alloc_preg;
      old_preg_mem[tail_idx] <= alloc_old_preg;
    end
    if (ex_fire) begin
      val_mem[ex_rob_entry_idx] <= ex_val;
    end
  end

  // Head/tail pointers and occupancy; a flush empties the buffer
  always_ff @(posedge clk) begin
    if (rst || flush_cond) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (alloc_fire) tail_reg <= tail_reg + PTR_ONE;
      if (commit_fire) head_reg <= head_reg + PTR_ONE;
      case ({alloc_fire, commit_fire})
        2'b10:   count_reg <= count_reg + PTR_ONE;
        2'b01:   count_reg <= count_reg - PTR_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Retire outputs: pulses for valid/flush/exception, fields hold between commits
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid_reg    <= 1'b0;
      commit_areg_reg     <= '0;
      commit_preg_reg     <= '0;
      commit_old_preg_reg <= '0;
      commit_val_reg      <= '0;
      flush_reg           <= 1'b0;
      exception_out_reg   <= 1'b0;
    end else begin
      // A mispredicted branch still retires; an excepting instruction does not
      commit_valid_reg  <= commit_cond && !head_exc;
      flush_reg         <= flush_cond;
      exception_out_reg <= flush_cond && head_exc;
      if (commit_cond && !head_exc) begin
        commit_areg_reg     <= areg_mem[head_idx];
        commit_preg_reg     <= preg_mem[head_idx];
        commit_old_preg_reg <= old_preg_mem[head_idx];
        commit_val_reg      <= val_mem[head_idx];
      end
    end
  end

  assign commit_valid    = commit_valid_reg;
  assign commit_areg     = commit_areg_reg;
  assign commit_preg     = commit_preg_reg;
  assign commit_old_preg = commit_old_preg_reg;
  assign commit_val      = commit_val_reg;
  assign flush           = flush_reg;
  assign exception_out   = exception_out_reg;
  assign count           = count_reg;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a
// randomized run compared against a queue-based in-order model.
module tb_reorder_buffer;

  localparam int DEPTH = 16;
  localparam int IW    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_areg;
  logic [5:0]  alloc_preg;
  logic [5:0]  alloc_old_preg;
  logic        alloc_ready;
  logic [3:0]  alloc_idx;
  logic        ex_valid;
  logic [3:0]  ex_rob_entry_idx;
  logic [31:0] ex_val;
  logic        ex_br_mispred;
  logic        ex_exception;
  logic        commit_valid;
  logic [4:0]  commit_areg;
  logic [5:0]  commit_preg;
  logic [5:0]  commit_old_preg;
  logic [31:0] commit_val;
  logic        flush;
  logic        exception_out;
  logic [4:0]  count;

  reorder_buffer #(.ROB_DEPTH(DEPTH), .PREG_W(6), .AREG_W(5)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_areg(alloc_areg), .alloc_preg(alloc_preg),
    .alloc_old_preg(alloc_old_preg), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .ex_valid(ex_valid), .ex_rob_entry_idx(ex_rob_entry_idx), .ex_val(ex_val),
    .ex_br_mispred(ex_br_mispred), .ex_exception(ex_exception),
    .commit_valid(commit_valid), .commit_areg(commit_areg), .commit_preg(commit_preg),
    .commit_old_preg(commit_old_preg), .commit_val(commit_val),
    .flush(flush), .exception_out(exception_out), .count(count)
  );

  always #5 clk = ~clk;

  // In-order model: a queue of in-flight instructions, oldest first
  typedef struct {
    int          idx;
    logic [4:0]  areg;
    logic [5:0]  preg;
    logic [5:0]  oldp;
    bit          done;
    bit          misp;
    bit          exc;
    logic [31:0] val;
  } ent_t;

  ent_t q[$];
  int   next_idx;

  // Model expectations after the most recent edge
  bit          e_cv, e_fl, e_ex;
  logic [4:0]  e_areg;
  logic [5:0]  e_preg, e_oldp;
  logic [31:0] e_val;
  // Model and DUT combinational outputs just before the most recent edge
  bit          m_ready;
  int          m_idx;
  logic        pre_ready;
  logic [3:0]  pre_idx;

  int n_checks = 0;
  int n_errors = 0;

  // One clock: capture pre-edge comb outputs, advance model, deassert strobes
  task automatic cycle();
    bit h_commit, h_flush, h_exc;
    ent_t h;
    #1;
    h_commit = 0; h_flush = 0; h_exc = 0;
    if (q.size() > 0) begin
      h = q[0];
      h_commit = h.done;
      h_flush  = h.done && (h.misp || h.exc);
      h_exc    = h.exc;
    end
    m_ready   = (q.size() != DEPTH) && !h_flush;
    m_idx     = next_idx;
    pre_ready = alloc_ready;
    pre_idx   = alloc_idx;
    @(posedge clk);
    if (rst) begin
      q.delete();
      next_idx = 0;
      e_cv = 0; e_fl = 0; e_ex = 0;
      e_areg = '0; e_preg = '0; e_oldp = '0; e_val = '0;
    end else begin
      e_cv = h_commit && !h_exc;
      e_fl = h_flush;
      e_ex = h_flush && h_exc;
      if (e_cv) begin
        e_areg = h.areg; e_preg = h.preg; e_oldp = h.oldp; e_val = h.val;
      end
      if (h_flush) begin
        q.delete();
        next_idx = 0;
      end else begin
        if (h_commit) void'(q.pop_front());
        if (ex_valid) begin
          foreach (q[i]) begin
            if (q[i].idx == int'(ex_rob_entry_idx)) begin
              q[i].done = 1; q[i].val = ex_val;
              q[i].misp = ex_br_mispred; q[i].exc = ex_exception;
            end
          end
        end
        if (alloc_valid && m_ready) begin
          h.idx = next_idx; h.areg = alloc_areg; h.preg = alloc_preg;
          h.oldp = alloc_old_preg; h.done = 0; h.misp = 0; h.exc = 0; h.val = '0;
          q.push_back(h);
          next_idx = (next_idx + 1) % DEPTH;
        end
      end
    end
    #1;
    if (commit_valid === 1'b1)
      $display("  commit areg=%0d preg=%0d old=%0d val=%h", commit_areg, commit_preg, commit_old_preg, commit_val);
    if (flush === 1'b1)
      $display("  flush exception=%0d", exception_out);
    alloc_valid   = 0;
    ex_valid      = 0;
    ex_br_mispred = 0;
    ex_exception  = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  task automatic alloc_one(input int areg, input int preg, input int oldp);
    alloc_valid = 1; alloc_areg = 5'(areg); alloc_preg = 6'(preg); alloc_old_preg = 6'(oldp);
    cycle();
  endtask

  task automatic complete(input int idx, input logic [31:0] v, input bit m, input bit e);
    ex_valid = 1; ex_rob_entry_idx = 4'(idx); ex_val = v; ex_br_mispred = m; ex_exception = e;
    cycle();
  endtask

  task automatic test_reset();
    do_reset();
    $display("test_reset");
    n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL reset_commit_valid: got %0b expected 0", commit_valid); end
    n_checks++; if (flush !== 1'b0 || exception_out !== 1'b0) begin n_errors++; $display("FAIL reset_flush: got %0b/%0b expected 0/0", flush, exception_out); end
    n_checks++; if (commit_val !== 32'd0 || commit_areg !== 5'd0) begin n_errors++; $display("FAIL reset_fields: got %h/%0d expected 0/0", commit_val, commit_areg); end
    n_checks++; if (alloc_ready !== 1'b1 || alloc_idx !== 4'd0) begin n_errors++; $display("FAIL reset_alloc: got %0b/%0d expected 1/0", alloc_ready, alloc_idx); end
  endtask

  task automatic test_in_order();
    do_reset();
    $display("test_in_order");
    for (int i = 0; i < 3; i++) begin
      alloc_one(i + 1, 10 + i, 20 + i);
      n_checks++; if (pre_idx !== 4'(i)) begin n_errors++; $display("FAIL io_alloc_idx: got %0d expected %0d", pre_idx, i); end
    end
    n_checks++; if (count !== 5'd3) begin n_errors++; $display("FAIL io_count3: got %0d expected 3", count); end
    n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL io_no_commit: got %0b expected 0", commit_valid); end
    complete(2, 32'hA, 0, 0);
    n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL io_early_commit: got %0b expected 0", commit_valid); end
    complete(0, 32'hB, 0, 0);
    n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL io_latency: got %0b expected 0", commit_valid); end
    complete(1, 32'hC, 0, 0);
    n_checks++; if (commit_valid !== 1'b1 || commit_val !== 32'hB || commit_areg !== 5'd1) begin n_errors++; $display("FAIL io_commit0: got v=%0b val=%h areg=%0d expected 1/b/1", commit_valid, commit_val, commit_areg); end
    n_checks++; if (commit_preg !== 6'd10 || commit_old_preg !== 6'd20) begin n_errors++; $display("FAIL io_commit0_preg: got %0d/%0d expected 10/20", commit_preg, commit_old_preg); end
    cycle();
    n_checks++; if (commit_valid !== 1'b1 || commit_val !== 32'hC || commit_areg !== 5'd2) begin n_errors++; $display("FAIL io_commit1: got v=%0b val=%h areg=%0d expected 1/c/2", commit_valid, commit_val, commit_areg); end
    cycle();
    n_checks++; if (commit_valid !== 1'b1 || commit_val !== 32'hA || commit_areg !== 5'd3) begin n_errors++; $display("FAIL io_commit2: got v=%0b val=%h areg=%0d expected 1/a/3", commit_valid, commit_val, commit_areg); end
    n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL io_count0: got %0d expected 0", count); end
    cycle();
    n_checks++; if (commit_valid !== 1'b0 || commit_val !== 32'hA) begin n_errors++; $display("FAIL io_pulse_hold: got v=%0b val=%h expected 0/a", commit_valid, commit_val); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    $display("test_full_wrap");
    for (int i = 0; i < DEPTH; i++) begin
      alloc_one(i, i + 30, i);
      n_checks++; if (pre_idx !== 4'(i) || pre_ready !== 1'b1) begin n_errors++; $display("FAIL fw_alloc: got idx=%0d rdy=%0b expected %0d/1", pre_idx, pre_ready, i); end
    end
    n_checks++; if (count !== 5'd16 || alloc_ready !== 1'b0) begin n_errors++; $display("FAIL fw_full: got cnt=%0d rdy=%0b expected 16/0", count, alloc_ready); end
    alloc_one(7, 7, 7);
    n_checks++; if (pre_ready !== 1'b0 || count !== 5'd16) begin n_errors++; $display("FAIL fw_17th: got rdy=%0b cnt=%0d expected 0/16", pre_ready, count); end
    complete(0, 32'h55, 0, 0);
    alloc_one(9, 9, 9);
    n_checks++; if (pre_ready !== 1'b0) begin n_errors++; $display("FAIL fw_commit_alloc_ready: got %0b expected 0", pre_ready); end
    n_checks++; if (commit_valid !== 1'b1 || commit_val !== 32'h55 || count !== 5'd15) begin n_errors++; $display("FAIL fw_commit: got v=%0b val=%h cnt=%0d expected 1/55/15", commit_valid, commit_val, count); end
    alloc_one(9, 9, 9);
    n_checks++; if (pre_ready !== 1'b1 || pre_idx !== 4'd0 || count !== 5'd16) begin n_errors++; $display("FAIL fw_wrap: got rdy=%0b idx=%0d cnt=%0d expected 1/0/16", pre_ready, pre_idx, count); end
  endtask

  task automatic test_mispredict();
    do_reset();
    $display("test_mispredict");
    for (int i = 0; i < 4; i++) alloc_one(i + 1, i + 40, i);
    complete(1, 32'h11, 1, 0);
    complete(0, 32'h10, 0, 0);
    cycle();
    n_checks++; if (commit_valid !== 1'b1 || commit_val !== 32'h10 || flush !== 1'b0) begin n_errors++; $display("FAIL mp_commit0: got v=%0b val=%h fl=%0b expected 1/10/0", commit_valid, commit_val, flush); end
    alloc_one(6, 6, 6);
    n_checks++; if (pre_ready !== 1'b0) begin n_errors++; $display("FAIL mp_alloc_block: got %0b expected 0", pre_ready); end
    n_checks++; if (commit_valid !== 1'b1 || commit_val !== 32'h11 || commit_areg !== 5'd2) begin n_errors++; $display("FAIL mp_branch_retire: got v=%0b val=%h areg=%0d expected 1/11/2", commit_valid, commit_val, commit_areg); end
    n_checks++; if (flush !== 1'b1 || exception_out !== 1'b0 || count !== 5'd0) begin n_errors++; $display("FAIL mp_flush: got fl=%0b ex=%0b cnt=%0d expected 1/0/0", flush, exception_out, count); end
    complete(2, 32'h22, 0, 0);
    n_checks++; if (flush !== 1'b0 || commit_valid !== 1'b0 || count !== 5'd0) begin n_errors++; $display("FAIL mp_after: got fl=%0b v=%0b cnt=%0d expected 0/0/0", flush, commit_valid, count); end
    alloc_one(8, 8, 8);
    n_checks++; if (pre_idx !== 4'd0 || count !== 5'd1) begin n_errors++; $display("FAIL mp_realloc: got idx=%0d cnt=%0d expected 0/1", pre_idx, count); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL mp_no_commit: got %0b expected 0", commit_valid); end
    end
  endtask

  task automatic test_exception();
    do_reset();
    $display("test_exception");
    alloc_one(1, 1, 1);
    alloc_one(2, 2, 2);
    complete(0, 32'hE0, 1, 1);
    ex_valid = 1; ex_rob_entry_idx = 4'd1; ex_val = 32'hE1;
    alloc_one(3, 3, 3);
    n_checks++; if (pre_ready !== 1'b0) begin n_errors++; $display("FAIL exc_alloc_block: got %0b expected 0", pre_ready); end
    n_checks++; if (commit_valid !== 1'b0 || flush !== 1'b1 || exception_out !== 1'b1) begin n_errors++; $display("FAIL exc_flush: got v=%0b fl=%0b ex=%0b expected 0/1/1", commit_valid, flush, exception_out); end
    n_checks++; if (count !== 5'd0 || commit_val !== 32'd0) begin n_errors++; $display("FAIL exc_state: got cnt=%0d val=%h expected 0/0", count, commit_val); end
    cycle();
    n_checks++; if (flush !== 1'b0 || exception_out !== 1'b0) begin n_errors++; $display("FAIL exc_pulse: got %0b/%0b expected 0/0", flush, exception_out); end
    alloc_one(4, 4, 4);
    n_checks++; if (pre_idx !== 4'd0 || count !== 5'd1) begin n_errors++; $display("FAIL exc_realloc: got idx=%0d cnt=%0d expected 0/1", pre_idx, count); end
    cycle();
    cycle();
    n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL exc_discard: got %0b expected 0", commit_valid); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    $display("test_reset_midflight");
    for (int i = 0; i < 5; i++) alloc_one(i + 1, i + 1, i + 1);
    complete(1, 32'h71, 0, 0);
    complete(0, 32'h70, 1, 0);
    rst = 1;
    cycle();
    rst = 0;
    n_checks++; if (count !== 5'd0 || commit_valid !== 1'b0 || flush !== 1'b0 || exception_out !== 1'b0) begin n_errors++; $display("FAIL rm_reset: got cnt=%0d v=%0b fl=%0b ex=%0b expected 0/0/0/0", count, commit_valid, flush, exception_out); end
    n_checks++; if (alloc_idx !== 4'd0 || alloc_ready !== 1'b1) begin n_errors++; $display("FAIL rm_alloc: got idx=%0d rdy=%0b expected 0/1", alloc_idx, alloc_ready); end
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++; if (commit_valid !== 1'b0 || flush !== 1'b0) begin n_errors++; $display("FAIL rm_quiet: got v=%0b fl=%0b expected 0/0", commit_valid, flush); end
    end
  endtask

  task automatic test_random();
    do_reset();
    $display("test_random");
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(299) == 0);
      if ($urandom_range(99) < 60) begin
        alloc_valid = 1; alloc_areg = 5'($urandom); alloc_preg = 6'($urandom); alloc_old_preg = 6'($urandom);
      end
      if ($urandom_range(99) < 50) begin
        ex_valid = 1;
        if (q.size() == 0 || $urandom_range(9) == 0) ex_rob_entry_idx = 4'($urandom_range(DEPTH - 1));
        else ex_rob_entry_idx = 4'(q[$urandom_range(q.size() - 1)].idx);
        ex_val = $urandom;
        ex_br_mispred = ($urandom_range(99) < 5);
        ex_exception  = ($urandom_range(99) < 3);
      end
      cycle();
      rst = 0;
      n_checks++; if (pre_ready !== m_ready) begin n_errors++; $display("FAIL rnd_ready c%0d: got %0b expected %0b", c, pre_ready, m_ready); end
      n_checks++; if (pre_idx !== 4'(m_idx)) begin n_errors++; $display("FAIL rnd_idx c%0d: got %0d expected %0d", c, pre_idx, m_idx); end
      n_checks++; if (commit_valid !== e_cv || flush !== e_fl || exception_out !== e_ex) begin n_errors++; $display("FAIL rnd_pulses c%0d: got %0b%0b%0b expected %0b%0b%0b", c, commit_valid, flush, exception_out, e_cv, e_fl, e_ex); end
      n_checks++; if (commit_areg !== e_areg || commit_preg !== e_preg || commit_old_preg !== e_oldp || commit_val !== e_val) begin n_errors++; $display("FAIL rnd_fields c%0d: got %0d/%0d/%0d/%h expected %0d/%0d/%0d/%h", c, commit_areg, commit_preg, commit_old_preg, commit_val, e_areg, e_preg, e_oldp, e_val); end
      n_checks++; if (count !== 5'(q.size())) begin n_errors++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, count, q.size()); end
    end
  endtask

  initial begin
    rst = 1; alloc_valid = 0; alloc_areg = '0; alloc_preg = '0; alloc_old_preg = '0;
    ex_valid = 0; ex_rob_entry_idx = '0; ex_val = '0; ex_br_mispred = 0; ex_exception = 0;
    next_idx = 0;
    test_reset();
    test_in_order();
    test_full_wrap();
    test_mispredict();
    test_exception();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer.
- Dispatch allocates one entry per cycle at the tail and returns its index.
- Execute units later mark the entry complete using that index, together with the result value and the branch-mispredict/exception flags.
- Retires at most one completed head entry per cycle to architectural commit logic, and raises a one-cycle flush when the retiring entry mispredicted or excepted.

Parameters:
- ROB_DEPTH, 16, number of entries; power of two, ≥4
- IDX_W, $clog2(ROB_DEPTH), entry index width
- PREG_W, 6, physical register index width
- AREG_W, 5, architectural register index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_valid  in  1  dispatch requests an entry
- alloc_areg  in  AREG_W  architectural destination
- alloc_preg  in  PREG_W  newly mapped physical destination
- alloc_old_preg  in  PREG_W  previous mapping, freed at commit
- alloc_ready  out  1  entry available this cycle (combinational)
- alloc_idx  out  IDX_W  index granted to the current alloc (the tail, combinational)
- ex_valid  in  1  execute completion strobe
- ex_rob_entry_idx  in  IDX_W  entry being completed
- ex_val  in  32  result value
- ex_br_mispred  in  1  branch outcome differed from prediction
- ex_exception  in  1  instruction raised an exception
- commit_valid  out  1  registered; one entry retired
- commit_areg  out  AREG_W  retired architectural destination
- commit_preg  out  PREG_W  retired physical destination
- commit_old_preg  out  PREG_W  physical register to free
- commit_val  out  32  retired result
- flush  out  1  registered one-cycle pipeline flush pulse
- exception_out  out  1  registered; asserted with flush when the cause was an exception
- count  out  IDX_W+1  occupied entries (registered)

Behaviour:

Reset:
- One clk with rst high clears head, tail, count and every entry valid/done bit.
- Registered outputs (commit_*, flush, exception_out) return to 0.
- rst mid-operation discards all in-flight entries; no commit or flush is emitted for them.

Storage and pointers:
- Per-entry fields: valid, done, mispred, exc, areg, preg, old_preg, val.
- head and tail are IDX_W+1 bits wide. The index is the low IDX_W bits; the MSB is a wrap bit.
- Full when count == ROB_DEPTH; empty when count == 0.

Allocation:
- alloc_ready = (count != ROB_DEPTH) && !flush_cond.
- An entry is written only when alloc_valid && alloc_ready. The write sets valid=1, done=0, mispred=0, exc=0, stores areg/preg/old_preg, and increments tail (wrapping).
- alloc_valid while not ready is ignored; nothing is written and no state changes.

Completion:
- On ex_valid, the entry at ex_rob_entry_idx gets done=1, val=ex_val, mispred=ex_br_mispred, exc=ex_exception.
- Completion targeting an entry with valid=0 is ignored. This covers stale results after a flush.
- Completion is visible to commit one cycle later: commit examines registered done.

Commit, evaluated each cycle on the head entry H:
- commit_cond = H.valid && H.done.
- flush_cond = commit_cond && (H.mispred || H.exc).
- Normal commit (commit_cond && !flush_cond):
  - Next cycle commit_valid=1 with H's fields.
  - H.valid cleared; head increments (wrapping).
- Mispredict commit (commit_cond, H.mispred, !H.exc):
  - Next cycle commit_valid=1 with H's fields; the branch itself retires.
  - flush=1 and exception_out=0 on the same cycle.
- Exception commit (commit_cond, H.exc; exc takes priority over mispred):
  - Next cycle commit_valid=0, flush=1, exception_out=1.
- On any flush_cond edge: all valid bits are cleared, head=tail=0, count=0.
- Allocations that cycle are blocked, because alloc_ready=0.
- Completions that cycle are dropped.
- commit_valid, flush and exception_out are single-cycle pulses; the commit_* fields hold their last value otherwise.

Count:
- count increments on alloc only, decrements on commit only, and is unchanged on simultaneous alloc and commit.
- Simultaneous alloc into a full buffer while the head commits is not accepted: alloc_ready is based on the registered count.

Latency:
- Completion at edge N → earliest commit_valid after edge N+1.
- Commit throughput is 1 per cycle.

Test Plan:
- Reset, then allocate 3 entries (areg 1,2,3; preg 10,11,12) → alloc_idx 0,1,2; count=3; no commit_valid.
- Complete idx 2, then idx 0, then idx 1, with ex_val 0xA,0xB,0xC respectively → commits appear in order idx 0,1,2 with commit_val 0xB,0xC,0xA on consecutive cycles; count reaches 0.
- Allocate 16 entries → alloc_ready=0 at count=16; a 17th alloc_valid is ignored. Commit one entry and allocate again → alloc_idx=0 (wrap); count back to 16.
- Allocate 4 entries, complete idx 1 with ex_br_mispred=1, complete idx 0 → idx 0 commits, then idx 1 commits with flush=1, exception_out=0; count=0. A later ex_valid to idx 2 is ignored; the next alloc gets idx 0.
- Allocate 2 entries, complete idx 0 with ex_exception=1 and ex_br_mispred=1 → flush=1, exception_out=1, commit_valid=0; entry 1 is discarded.
- Assert rst while 5 entries are in flight and 2 are completed → count=0 and all outputs 0 the next cycle; no commit or flush pulses appear afterwards.
